// File: rtl/bram_tx_stage.sv
// Transmit stage: reads a DEPTH-byte frame from BRAM port B, optionally prepends a
// header byte, and streams each byte through a UART using its tx_start/tx_busy handshake.
module bram_tx_stage #(
    parameter int                DEPTH       = 64,
    parameter int                ADDR_W      = 6,
    parameter int                DATA_W      = 8,
    parameter int                RD_LATENCY  = 1,
    parameter bit                HEADER_EN   = 1'b1,
    parameter logic [DATA_W-1:0] HEADER_BYTE = 8'h01
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_RD_WAIT,
        S_LOAD,
        S_SEND,
        S_ACK,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 2);
    localparam logic [1:0]        ACK_LAST  = 2'd3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [ADDR_W-1:0]   r_cnt;
    logic [1:0]          r_wait_cnt;
    logic [1:0]          r_ack_cnt;
    logic                r_hdr_phase;
    logic                r_busy;
    logic                r_done;
    logic                r_rd_en;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;

    // Reset asserts asynchronously but releases two clocks after reset_n rises,
    // so no flop sees reset removal close to an active edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        // NOTE: default assigned first so every path drives w_state_nxt; a missing
        // assignment on any branch would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = HEADER_EN ? S_HDR : S_RD;
            S_HDR:     w_state_nxt = S_SEND;
            S_RD:      w_state_nxt = (RD_LATENCY > 1) ? S_RD_WAIT : S_LOAD;
            S_RD_WAIT: if (r_wait_cnt == WAIT_LAST) w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = S_SEND;
            S_SEND:    if (!tx_busy) w_state_nxt = S_ACK;
            S_ACK:     if (tx_busy || (r_ack_cnt == ACK_LAST)) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (r_hdr_phase || (r_cnt != CNT_LAST)) begin
                        w_state_nxt = S_RD;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they are glitch-free
    // and line up exactly with the cycle spent in the corresponding state.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_cnt       <= '0;
            r_wait_cnt  <= '0;
            r_ack_cnt   <= '0;
            r_hdr_phase <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values,
            // independent of statement order within this block.
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_rd_en    <= (w_state_nxt == S_RD);
            r_tx_start <= (r_state == S_SEND) && !tx_busy;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt       <= '0;
                        r_hdr_phase <= HEADER_EN;
                    end
                end
                S_HDR:     r_tx_data  <= HEADER_BYTE;
                S_RD:      r_wait_cnt <= '0;
                S_RD_WAIT: r_wait_cnt <= r_wait_cnt + 2'd1;
                S_LOAD:    r_tx_data  <= rd_data;
                S_SEND:    r_ack_cnt  <= '0;
                S_ACK:     r_ack_cnt  <= r_ack_cnt + 2'd1;
                S_DRAIN: begin
                    if (!tx_busy) begin
                        if (r_hdr_phase) begin
                            r_hdr_phase <= 1'b0;
                        end else if (r_cnt != CNT_LAST) begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_en    = r_rd_en;
    assign rd_addr  = r_cnt;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;

endmodule

// File: tb/tb_bram_tx_stage.sv
// Directed bench for bram_tx_stage: two instances (1-cycle BRAM with header, 2-cycle
// BRAM without header) driven by negedge BRAM and UART models.
`timescale 1ns/1ps
module tb_bram_tx_stage;

    localparam int DEPTH    = 64;
    localparam int BUSY_CYC = 12;
    localparam int BUDGET   = 5000;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_a [DEPTH];
    logic [7:0] mem_b [DEPTH];

    // Instance A: RD_LATENCY=1, header enabled
    logic       a_start = 1'b0;
    logic       a_busy, a_done, a_rd_en, a_tx_start;
    logic [5:0] a_rd_addr;
    logic [7:0] a_rd_data = 8'hEE;
    logic [7:0] a_tx_data;
    logic       a_tx_busy;
    logic       a_ub = 1'b0;
    logic       a_hold = 1'b0;
    bit         a_pv = 1'b0;
    logic [5:0] a_pa = '0;
    int a_cyc = 0, a_fall_cyc = 0, a_gap = 0, a_ucnt = 0, a_starts = 0;
    int a_rd_cnt = 0, a_addr_err = 0, a_done_cnt = 0, a_exp_addr = 0, a_drop_idx = -1;
    logic [7:0] a_bytes[$];

    // Instance B: RD_LATENCY=2, no header
    logic       b_start = 1'b0;
    logic       b_busy, b_done, b_rd_en, b_tx_start;
    logic [5:0] b_rd_addr;
    logic [7:0] b_rd_data = 8'hEE;
    logic [7:0] b_tx_data;
    logic       b_tx_busy;
    logic       b_ub = 1'b0;
    bit         b_pv0 = 1'b0, b_pv1 = 1'b0;
    logic [5:0] b_pa0 = '0, b_pa1 = '0;
    int b_cyc = 0, b_fall_cyc = 0, b_gap = 0, b_ucnt = 0, b_starts = 0;
    int b_rd_cnt = 0, b_addr_err = 0, b_done_cnt = 0, b_exp_addr = 0;
    logic [7:0] b_bytes[$];

    assign a_tx_busy = a_ub | a_hold;
    assign b_tx_busy = b_ub;

    bram_tx_stage #(
        .DEPTH(64), .ADDR_W(6), .DATA_W(8), .RD_LATENCY(1),
        .HEADER_EN(1'b1), .HEADER_BYTE(8'h01)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .tx_data(a_tx_data), .tx_start(a_tx_start), .tx_busy(a_tx_busy)
    );

    bram_tx_stage #(
        .DEPTH(64), .ADDR_W(6), .DATA_W(8), .RD_LATENCY(2),
        .HEADER_EN(1'b0), .HEADER_BYTE(8'h01)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .tx_data(b_tx_data), .tx_start(b_tx_start), .tx_busy(b_tx_busy)
    );

    // BRAM data appears only in the window the DUT must sample; otherwise 0xEE.
    always @(negedge clk) begin
        a_cyc++;
        a_rd_data = a_pv ? mem_a[a_pa] : 8'hEE;
        a_pv = a_rd_en;
        a_pa = a_rd_addr;
        if (a_rd_en) begin
            if (a_rd_addr != 6'(a_exp_addr)) a_addr_err++;
            a_exp_addr++;
            a_rd_cnt++;
        end
        if (a_done) a_done_cnt++;
        if (a_ucnt > 0) begin
            a_ucnt--;
            if (a_ucnt == 0) begin
                a_ub = 1'b0;
                a_fall_cyc = a_cyc;
            end
        end
        if (a_tx_start) begin
            a_bytes.push_back(a_tx_data);
            a_gap = a_cyc - a_fall_cyc;
            if (a_starts != a_drop_idx) begin
                a_ub = 1'b1;
                a_ucnt = BUSY_CYC;
            end
            a_starts++;
        end
    end

    always @(negedge clk) begin
        b_cyc++;
        b_rd_data = b_pv1 ? mem_b[b_pa1] : 8'hEE;
        b_pv1 = b_pv0;
        b_pa1 = b_pa0;
        b_pv0 = b_rd_en;
        b_pa0 = b_rd_addr;
        if (b_rd_en) begin
            if (b_rd_addr != 6'(b_exp_addr)) b_addr_err++;
            b_exp_addr++;
            b_rd_cnt++;
        end
        if (b_done) b_done_cnt++;
        if (b_ucnt > 0) begin
            b_ucnt--;
            if (b_ucnt == 0) begin
                b_ub = 1'b0;
                b_fall_cyc = b_cyc;
            end
        end
        if (b_tx_start) begin
            b_bytes.push_back(b_tx_data);
            b_gap = b_cyc - b_fall_cyc;
            b_ub = 1'b1;
            b_ucnt = BUSY_CYC;
            b_starts++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_a();
        @(negedge clk);
        #1;
        a_bytes.delete();
        a_starts = 0; a_rd_cnt = 0; a_addr_err = 0; a_done_cnt = 0; a_exp_addr = 0;
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_rd_a(input string tag, input int target);
        int n = 0;
        while (a_rd_cnt < target && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, a_rd_cnt >= target, 1);
    endtask

    // Waits for done, then checks it is a single-cycle pulse with busy dropping after it.
    task automatic wait_done_a(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < BUDGET) begin
            @(negedge clk);
            #1;
            seen = a_done;
            n++;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_with_done"}, a_busy, 1);
        @(negedge clk);
        #1;
        check({tag, "_done_pulse_len"}, a_done, 0);
        check({tag, "_busy_after_done"}, a_busy, 0);
        repeat (20) @(negedge clk);
        #1;
    endtask

    task automatic check_frame_a(input string tag);
        int bad = 0;
        logic [7:0] first;
        first = (a_bytes.size() > 0) ? a_bytes[0] : 8'hXX;
        for (int k = 0; k + 1 < a_bytes.size(); k++) begin
            if (a_bytes[k + 1] !== 8'(k + 16)) bad++;
        end
        check({tag, "_nbytes"}, a_bytes.size(), 65);
        check({tag, "_hdr"}, first, 8'h01);
        check({tag, "_bad_bytes"}, bad, 0);
        check({tag, "_tx_starts"}, a_starts, 65);
        check({tag, "_rd_en_cnt"}, a_rd_cnt, 64);
        check({tag, "_addr_err"}, a_addr_err, 0);
        check({tag, "_done_cnt"}, a_done_cnt, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_a[k] = 8'(k + 16);
            mem_b[k] = 8'(k * 3 + 85);
        end

        // Reset state
        #1 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_rd_en", a_rd_en, 0);
        check("rst_tx_start", a_tx_start, 0);
        check("rst_rd_addr", a_rd_addr, 0);
        check("rst_tx_data", a_tx_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame with start-to-header timing
        clear_a();
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        check("e0_busy", a_busy, 1);
        @(negedge clk);
        a_start = 1'b0;
        @(posedge clk);
        #1;
        check("e1_tx_start", a_tx_start, 0);
        @(posedge clk);
        #1;
        check("e2_tx_start", a_tx_start, 1);
        check("e2_tx_data", a_tx_data, 8'h01);
        wait_done_a("basic");
        check_frame_a("basic");
        check("basic_byte_gap", a_gap, 4);

        // Start during a frame is ignored
        clear_a();
        pulse_start_a();
        wait_rd_a("ign_reach_byte10", 11);
        pulse_start_a();
        wait_done_a("ign");
        check_frame_a("ign");

        // Lost ack on data byte 5 (tx_start index 6)
        clear_a();
        a_drop_idx = 6;
        pulse_start_a();
        wait_done_a("lost");
        check_frame_a("lost");
        a_drop_idx = -1;

        // UART busy for 500 cycles at start
        clear_a();
        a_hold = 1'b1;
        pulse_start_a();
        repeat (500) @(negedge clk);
        #1;
        check("hold_no_tx_start", a_starts, 0);
        check("hold_busy", a_busy, 1);
        a_hold = 1'b0;
        @(posedge clk);
        #1;
        check("hold_release_tx_start", a_tx_start, 1);
        wait_done_a("hold");
        check_frame_a("hold");

        // Reset during byte 30, then a full frame from address 0
        clear_a();
        pulse_start_a();
        wait_rd_a("rst_reach_byte30", 31);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_outputs", {a_busy, a_done, a_rd_en, a_tx_start, a_rd_addr, a_tx_data}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("midrst_busy_after", a_busy, 0);
        check("midrst_no_done", a_done_cnt, 0);
        clear_a();
        pulse_start_a();
        wait_done_a("refrm");
        check_frame_a("refrm");

        // Two-cycle read latency, no header
        begin
            int n = 0;
            int bad = 0;
            @(negedge clk);
            b_bytes.delete();
            b_starts = 0; b_rd_cnt = 0; b_addr_err = 0; b_done_cnt = 0; b_exp_addr = 0;
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            while (b_done_cnt == 0 && n < BUDGET) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("lat2_done_seen", b_done_cnt != 0, 1);
            repeat (20) @(negedge clk);
            #1;
            for (int k = 0; k < b_bytes.size(); k++) begin
                if (k < DEPTH && b_bytes[k] !== mem_b[k]) bad++;
            end
            check("lat2_nbytes", b_bytes.size(), 64);
            check("lat2_bad_bytes", bad, 0);
            check("lat2_rd_en_cnt", b_rd_cnt, 64);
            check("lat2_addr_err", b_addr_err, 0);
            check("lat2_done_cnt", b_done_cnt, 1);
            check("lat2_byte_gap", b_gap, 5);
            check("lat2_busy_end", b_busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_tx_stage.md
# bram_tx_stage

Transmit stage downstream of the UART reception stage. When triggered, it reads a DEPTH-byte frame from port B of the shared frame BRAM (BRAM A), optionally prepends a header byte, and streams every byte out through the `uart_basic` transmitter using its `tx_start`/`tx_busy` handshake. It pulses `done` when the last byte has left the UART. It sits between BRAM A and `uart_basic`, and replaces the transmit-side control wrapper when frames are echoed or forwarded.

## Interface
- `DEPTH`, 64: frame length in bytes; must equal the reception-stage frame length.
- `ADDR_W`, 6: BRAM address width; 2^ADDR_W >= DEPTH.
- `DATA_W`, 8: byte width.
- `RD_LATENCY`, 1: BRAM port B read latency in cycles, legal values 1 or 2.
- `HEADER_EN`, 1: 1 = send `HEADER_BYTE` before the frame.
- `HEADER_BYTE`, 8'h01: header value, matching the reception-stage start token.

Ports:
- `clk` in 1: single system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to send a frame; ignored unless `busy`=0.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse after the final byte's `tx_busy` falls.
- `rd_en` out 1: BRAM port B enable, one cycle per byte.
- `rd_addr` out ADDR_W: BRAM port B address.
- `rd_data` in DATA_W: BRAM port B read data.
- `tx_data` out DATA_W: byte to the UART; registered and held until the next load.
- `tx_start` out 1: one-cycle UART start pulse.
- `tx_busy` in 1: UART transmitter busy.

## Operation
- Reset (asynchronous assert, synchronous release): state IDLE; `busy`, `done`, `rd_en`, `tx_start` = 0; `rd_addr` = 0; `tx_data` = 0; byte counter = 0.
- States: IDLE, HDR, RD, RD_WAIT, LOAD, SEND, ACK, DRAIN, DONE.
- IDLE: when `start`=1 the block accepts the request and clears the counter. It goes to HDR if `HEADER_EN` else RD.
- HDR: load `tx_data`=`HEADER_BYTE`, then go to SEND.
- RD: `rd_en`=1, `rd_addr`=counter, then go to RD_WAIT.
- RD_WAIT: wait RD_LATENCY-1 further cycles (0 when RD_LATENCY=1), then go to LOAD.
- LOAD: `tx_data` <= `rd_data`, then go to SEND.
- SEND: wait while `tx_busy`=1. When `tx_busy`=0, pulse `tx_start` for one cycle and go to ACK.
- ACK: wait for `tx_busy`=1, then go to DRAIN. If `tx_busy` does not rise within 4 cycles, go to DRAIN anyway (lost-ack guard).
- DRAIN: wait for `tx_busy`=0. After the header go to RD. After a data byte: if counter = DEPTH-1 go to DONE, else counter+1 and go to RD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Counter is ADDR_W bits and never wraps; addresses issued are exactly 0..DEPTH-1, in order, each once.
- `start` asserted in any state other than IDLE is ignored and not queued.
- Reset during any state aborts the frame. The frame is not resumed, and no `done` is produced for it.
- `tx_data` changes only in HDR or LOAD, so it is stable for the entire `tx_start` cycle and the UART busy period.

## Timing
- `start` is sampled at edge E0 with HEADER_EN=1 and the UART idle:
  - `busy`=1 from E0.
  - Header `tx_start` high in cycle E2.
- Per data byte with the UART idle, from the DRAIN exit to `tx_start` is 3 + (RD_LATENCY-1) cycles: RD, [RD_WAIT], LOAD, SEND.
- `rd_data` is sampled exactly RD_LATENCY cycles after the `rd_en` cycle.
- `done` is asserted the cycle after DRAIN observes `tx_busy`=0 for byte DEPTH-1. `busy` deasserts with `done` at the following edge.
- Frame duration ≈ (DEPTH + HEADER_EN) × UART byte time (86.8 µs at 115200 baud) plus a few cycles per byte.

## Test plan
- Basic frame: preload BRAM[k]=k+0x10, DEPTH=64, HEADER_EN=1, UART model at 115200 → bytes 0x01, 0x10…0x4F decoded in order; exactly 65 `tx_start` pulses; one `done`.
- Read latency: RD_LATENCY=2, BRAM model with a 2-cycle read, HEADER_EN=0 → 64 bytes equal to memory contents, no off-by-one; `rd_addr` sequence 0..63.
- Busy UART: hold `tx_busy`=1 for 500 cycles at `start` → no `tx_start` until `tx_busy` falls; first byte then sent within 1 cycle.
- Ignored start: pulse `start` at byte 10 of a frame → no restart, no second frame; `done` count = 1.
- Lost ack: UART model never raises `tx_busy` for byte 5 → block advances after the 4-cycle guard; 64 `rd_en` pulses total; `done` asserted.
- Reset mid-frame: assert `reset_n`=0 during byte 30 → all outputs 0 immediately; after release, `busy`=0; a new `start` sends a full frame beginning at address 0.
